// File: rtl/serdes_pkg.sv
// Shared types and constants for the receive word aligner: K28.5 comma codes,
// aligner FSM states and the saturating 4-bit counter type.
package serdes_pkg;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } align_state_t;

  typedef logic [3:0] cnt_t;

  function automatic logic is_comma(input logic [9:0] w);
    return (w == K28_5_RDN) || (w == K28_5_RDP);
  endfunction

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

endpackage

// File: rtl/comma_aligner_if.sv
// Word stream from the SIPO into the aligner and the aligned stream/status out.
interface comma_aligner_if;
  import serdes_pkg::*;

  // One word per receive word clock, always valid; there is no backpressure,
  // so the aligner consumes every SIPO word and emits one word every cycle.
  logic [9:0]   RxParallel_10_in;
  logic [9:0]   RxParallel_10_out;
  logic         Comma_det;
  logic         Locked;
  logic [3:0]   Offset;
  align_state_t dbg_state;

  modport master (
    output RxParallel_10_in,
    input  RxParallel_10_out, Comma_det, Locked, Offset, dbg_state
  );

  modport slave (
    input  RxParallel_10_in,
    output RxParallel_10_out, Comma_det, Locked, Offset, dbg_state
  );

endinterface

// File: rtl/comma_search.sv
// Combinational K28.5 search over the ten 10-bit candidates of a 20-bit window;
// candidate k is window[19-k -: 10], lowest matching k wins.
module comma_search
  import serdes_pkg::*;
(
  input  logic [19:0] window_i,
  output logic        hit_o,
  output logic [3:0]  hit_k_o,
  output logic [9:0]  match_o
);

  always_comb begin
    match_o = '0;
    for (int k = 0; k < 10; k++) begin
      match_o[k] = is_comma(window_i[19-k -: 10]);
    end
  end

  assign hit_o = |match_o;

  always_comb begin
    hit_k_o = '0;
    for (int k = 9; k >= 0; k--) begin
      if (match_o[k]) hit_k_o = 4'(k);
    end
  end

endmodule

// File: rtl/comma_aligner.sv
// Receive word aligner: acquires K28.5 bit alignment, holds it once locked and
// presents word-aligned codes plus lock/offset status to the decoder.
module comma_aligner
  import serdes_pkg::*;
#(
  parameter int unsigned LOCK_COUNT   = 3,
  parameter int unsigned UNLOCK_COUNT = 4
) (
  input  logic             RxBitCLK_10,
  input  logic             Reset,
  comma_aligner_if.slave   rx
);

  localparam cnt_t LOCK_N   = cnt_t'(LOCK_COUNT);
  localparam cnt_t UNLOCK_N = cnt_t'(UNLOCK_COUNT);

  align_state_t state_q, state_d;
  cnt_t         good_q, good_d;
  cnt_t         bad_q, bad_d;
  logic [3:0]   off_q, off_d;
  logic [9:0]   prev_q;
  logic [9:0]   out_q;
  logic         det_q;
  logic         lock_q;
  logic [3:0]   offo_q;

  logic [19:0]  window;
  logic         hit;
  logic [3:0]   hit_k;
  logic [9:0]   match;
  logic [3:0]   eff;
  logic [9:0]   cand_eff;

  assign window = {prev_q, rx.RxParallel_10_in};

  comma_search u_search (
    .window_i (window),
    .hit_o    (hit),
    .hit_k_o  (hit_k),
    .match_o  (match)
  );

  // While acquiring, steer the output by the fresh hit so the acquiring comma
  // itself comes out aligned; once locked the offset is frozen.
  assign eff = (state_q != LOCKED && hit) ? hit_k : off_q;

  always_comb begin
    cand_eff = '0;
    for (int k = 0; k < 10; k++) begin
      if (eff == 4'(k)) cand_eff = window[19-k -: 10];
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    off_d   = off_q;
    case (state_q)
      UNLOCKED: begin
        if (hit) begin
          off_d   = hit_k;
          good_d  = 4'd1;
          bad_d   = '0;
          state_d = (LOCK_N == 4'd1) ? LOCKED : CHECK;
        end
      end
      CHECK: begin
        if (hit) begin
          if (hit_k == off_q) begin
            good_d = sat_inc(good_q);
            if (({1'b0, good_q} + 5'd1) == {1'b0, LOCK_N}) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else begin
            off_d  = hit_k;
            good_d = 4'd1;
          end
        end
      end
      LOCKED: begin
        // A comma at the held offset wins even if a lower offset also matches.
        if (match[off_q]) begin
          bad_d = '0;
        end else if (hit) begin
          if (({1'b0, bad_q} + 5'd1) == {1'b0, UNLOCK_N}) begin
            state_d = UNLOCKED;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            bad_d = sat_inc(bad_q);
          end
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge RxBitCLK_10 or negedge Reset) begin
    if (!Reset) begin
      state_q <= UNLOCKED;
      good_q  <= '0;
      bad_q   <= '0;
      off_q   <= '0;
      prev_q  <= '0;
      out_q   <= '0;
      det_q   <= 1'b0;
      lock_q  <= 1'b0;
      offo_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      off_q   <= off_d;
      prev_q  <= rx.RxParallel_10_in;
      out_q   <= cand_eff;
      det_q   <= is_comma(cand_eff);
      lock_q  <= (state_d == LOCKED);
      offo_q  <= eff;
    end
  end

  assign rx.RxParallel_10_out = out_q;
  assign rx.Comma_det         = det_q;
  assign rx.Locked            = lock_q;
  assign rx.Offset            = offo_q;
  assign rx.dbg_state         = state_q;

endmodule
